// File: rtl/llc_req_scheduler.sv
// LLC request scheduler: sorts commands into L1/snoop queues and issues one request per cycle,
// snoop-first with a starvation guard; op 9 is a barrier that drains both queues first.

module llc_req_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdat_i,
  output logic [W-1:0]  rdat_o,
  output logic [AW:0]   count_o
);
  localparam logic [AW:0] ONE = 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;

  // Pointers carry one extra bit so full and empty stay distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + ONE;
      if (pop_i)  rd_q <= rd_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= wdat_i;
  end

  assign rdat_o  = mem_q[rd_q[AW-1:0]];
  assign count_o = wr_q - rd_q;
endmodule

module llc_req_scheduler #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DEPTH         = 8,
  parameter int MAX_SNOOP_RUN = 4,
  parameter int IDLE_OP       = 8,
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [3:0]            in_op,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  in_ready,
  output logic                  in_err,
  output logic [3:0]            llc_op,
  output logic [ADDR_WIDTH-1:0] llc_addr,
  input  logic                  llc_hold,
  output logic [1:0]            grant_src,
  output logic [CW-1:0]         l1_count,
  output logic [CW-1:0]         snp_count,
  output logic                  busy
);
  localparam int QW = 4 + ADDR_WIDTH;
  localparam int RW = $clog2(MAX_SNOOP_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_SNOOP_RUN);
  localparam logic [RW-1:0] RUN_ONE  = 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, BARRIER} state_t;

  state_t                state_q, state_d;
  logic [3:0]            llc_op_q, llc_op_d;
  logic [ADDR_WIDTH-1:0] llc_addr_q, llc_addr_d, baddr_q, baddr_d;
  logic [1:0]            src_q, src_d;
  logic [RW-1:0]         run_q, run_d;
  logic                  bar_q, bar_d, err_q;

  logic [CW-1:0] l1_cnt, snp_cnt;
  logic [QW-1:0] l1_head, snp_head;
  logic          l1_pop, snp_pop, l1_ne, snp_ne, pick_snp;
  logic          is_l1, is_snp, is_bar, is_ill, acc;

  assign is_l1  = (in_op <= 4'd2);
  assign is_snp = (in_op >= 4'd3) && (in_op <= 4'd6);
  assign is_bar = (in_op == 4'd9);
  assign is_ill = !(is_l1 || is_snp || is_bar);

  // Fullness is judged on pre-edge occupancy: a pop on the same edge does not reopen the queue.
  assign in_ready = !bar_q && !(is_l1 && l1_cnt == CNT_FULL) && !(is_snp && snp_cnt == CNT_FULL);
  assign acc      = in_valid && in_ready;

  assign l1_ne    = (l1_cnt != '0);
  assign snp_ne   = (snp_cnt != '0);
  assign pick_snp = snp_ne && !(run_q == RUN_MAX && l1_ne);

  llc_req_fifo #(.W(QW), .DEPTH(DEPTH)) u_l1_q (
    .clk(clk), .rst_n(rst_n), .push_i(acc && is_l1), .pop_i(l1_pop),
    .wdat_i({in_op, in_addr}), .rdat_o(l1_head), .count_o(l1_cnt)
  );

  llc_req_fifo #(.W(QW), .DEPTH(DEPTH)) u_snp_q (
    .clk(clk), .rst_n(rst_n), .push_i(acc && is_snp), .pop_i(snp_pop),
    .wdat_i({in_op, in_addr}), .rdat_o(snp_head), .count_o(snp_cnt)
  );

  always_comb begin
    state_d    = state_q;
    llc_op_d   = llc_op_q;
    llc_addr_d = llc_addr_q;
    src_d      = src_q;
    run_d      = run_q;
    bar_d      = bar_q;
    baddr_d    = baddr_q;
    l1_pop     = 1'b0;
    snp_pop    = 1'b0;
    if (!llc_hold) begin
      if (state_q == BARRIER) begin
        llc_op_d   = 4'(IDLE_OP);
        llc_addr_d = '0;
        src_d      = 2'b00;
        bar_d      = 1'b0;
        state_d    = ISSUE;
      end else if (state_q == DRAIN && !l1_ne && !snp_ne) begin
        llc_op_d   = 4'd9;
        llc_addr_d = baddr_q;
        src_d      = 2'b11;
        run_d      = '0;
        state_d    = BARRIER;
      end else begin
        if (state_q == IDLE) state_d = ISSUE;
        if (pick_snp) begin
          snp_pop    = 1'b1;
          llc_op_d   = snp_head[QW-1 -: 4];
          llc_addr_d = snp_head[ADDR_WIDTH-1:0];
          src_d      = 2'b10;
          // The run only counts while an L1 request is actually waiting.
          run_d      = !l1_ne ? '0 : (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;
        end else if (l1_ne) begin
          l1_pop     = 1'b1;
          llc_op_d   = l1_head[QW-1 -: 4];
          llc_addr_d = l1_head[ADDR_WIDTH-1:0];
          src_d      = 2'b01;
          run_d      = '0;
        end else begin
          llc_op_d   = 4'(IDLE_OP);
          llc_addr_d = '0;
          src_d      = 2'b00;
          run_d      = '0;
        end
      end
    end
    if (acc && is_bar) begin
      bar_d   = 1'b1;
      baddr_d = in_addr;
      state_d = DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      llc_op_q   <= 4'(IDLE_OP);
      llc_addr_q <= '0;
      src_q      <= 2'b00;
      run_q      <= '0;
      bar_q      <= 1'b0;
      baddr_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      llc_op_q   <= llc_op_d;
      llc_addr_q <= llc_addr_d;
      src_q      <= src_d;
      run_q      <= run_d;
      bar_q      <= bar_d;
      baddr_q    <= baddr_d;
      err_q      <= acc && is_ill;
    end
  end

  assign llc_op    = llc_op_q;
  assign llc_addr  = llc_addr_q;
  assign grant_src = src_q;
  assign in_err    = err_q;
  assign l1_count  = l1_cnt;
  assign snp_count = snp_cnt;
  assign busy      = l1_ne || snp_ne || bar_q || (src_q != 2'b00);
endmodule

// File: tb/tb_llc_req_scheduler.sv
// Directed bench for llc_req_scheduler with a queue-level reference model checked every cycle.

module tb_llc_req_scheduler;
  localparam int AW    = 32;
  localparam int DEPTH = 8;
  localparam int MAXR  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [3:0]    in_op = 4'd0;
  logic [AW-1:0] in_addr = '0;
  logic          llc_hold = 1'b0;
  logic          in_ready, in_err, busy;
  logic [3:0]    llc_op;
  logic [AW-1:0] llc_addr;
  logic [1:0]    grant_src;
  logic [3:0]    l1_count, snp_count;

  int checks = 0;
  int errors = 0;

  llc_req_scheduler #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .MAX_SNOOP_RUN(MAXR), .IDLE_OP(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
    .in_ready(in_ready), .in_err(in_err), .llc_op(llc_op), .llc_addr(llc_addr),
    .llc_hold(llc_hold), .grant_src(grant_src), .l1_count(l1_count),
    .snp_count(snp_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: the two queues, the barrier, and the stream of grants it implies.
  logic [35:0] l1q[$];
  logic [35:0] snpq[$];
  logic [35:0] glog[$];
  int          run = 0;
  bit          bar = 1'b0, drain = 1'b0, in_bar = 1'b0, m_err = 1'b0;
  logic [31:0] baddr = '0, m_addr = '0;
  logic [3:0]  m_op = 4'd8;
  logic [1:0]  m_src = 2'd0;

  function automatic bit cls_l1(input logic [3:0] op);  return op <= 4'd2; endfunction
  function automatic bit cls_snp(input logic [3:0] op); return op >= 4'd3 && op <= 4'd6; endfunction

  function automatic bit exp_ready();
    if (bar) return 1'b0;
    if (cls_l1(in_op))  return l1q.size() < DEPTH;
    if (cls_snp(in_op)) return snpq.size() < DEPTH;
    return 1'b1;
  endfunction

  task automatic show(input logic [35:0] e, input logic [1:0] src);
    m_op = e[35:32]; m_addr = e[31:0]; m_src = src;
    if (src != 2'd0) glog.push_back(e);
  endtask

  task automatic model_step();
    bit acc;
    logic [35:0] e;
    if (!rst_n) begin
      l1q.delete(); snpq.delete();
      run = 0; bar = 1'b0; drain = 1'b0; in_bar = 1'b0; baddr = '0;
      m_op = 4'd8; m_addr = '0; m_src = 2'd0; m_err = 1'b0;
      return;
    end
    acc   = in_valid && exp_ready();
    m_err = acc && !cls_l1(in_op) && !cls_snp(in_op) && in_op != 4'd9;
    if (!llc_hold) begin
      if (in_bar) begin
        show({4'd8, 32'd0}, 2'd0);
        in_bar = 1'b0; bar = 1'b0; drain = 1'b0;
      end else if (drain && l1q.size() == 0 && snpq.size() == 0) begin
        show({4'd9, baddr}, 2'd3);
        in_bar = 1'b1; run = 0;
      end else if (snpq.size() > 0 && !(run == MAXR && l1q.size() > 0)) begin
        e = snpq.pop_front();
        show(e, 2'd2);
        run = (l1q.size() == 0) ? 0 : (run < MAXR ? run + 1 : MAXR);
      end else if (l1q.size() > 0) begin
        e = l1q.pop_front();
        show(e, 2'd1);
        run = 0;
      end else begin
        show({4'd8, 32'd0}, 2'd0);
        run = 0;
      end
    end
    if (acc) begin
      if (cls_l1(in_op))       l1q.push_back({in_op, in_addr});
      else if (cls_snp(in_op)) snpq.push_back({in_op, in_addr});
      else if (in_op == 4'd9) begin bar = 1'b1; drain = 1'b1; baddr = in_addr; end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #2;
    chk("llc_op",    64'(llc_op),    64'(m_op));
    chk("llc_addr",  64'(llc_addr),  64'(m_addr));
    chk("grant_src", 64'(grant_src), 64'(m_src));
    chk("l1_count",  64'(l1_count),  64'(l1q.size()));
    chk("snp_count", 64'(snp_count), 64'(snpq.size()));
    chk("in_err",    64'(in_err),    64'(m_err));
    chk("in_ready",  64'(in_ready),  64'(exp_ready()));
    chk("busy",      64'(busy),
        64'(l1q.size() > 0 || snpq.size() > 0 || bar || m_src != 2'd0));
  end

  // Drive one cycle of inputs at the falling edge, then settle just past the rising edge.
  task automatic step(input bit v, input logic [3:0] op, input logic [31:0] a, input bit h);
    @(negedge clk);
    in_valid = v; in_op = op; in_addr = a; llc_hold = h;
    @(posedge clk);
    #3;
  endtask

  task automatic chk_log(input string name, input int idx, input logic [35:0] exp);
    logic [35:0] got;
    got = (idx < glog.size()) ? glog[idx] : 36'hF_FFFF_FFFF;
    chk(name, 64'(got), 64'(exp));
  endtask

  initial begin
    int s;
    logic [35:0] exp3[7];
    logic [35:0] exp4[4];
    exp3 = '{{4'd3, 32'h10}, {4'd3, 32'h20}, {4'd3, 32'h30}, {4'd3, 32'h40},
             {4'd0, 32'h99}, {4'd3, 32'h50}, {4'd3, 32'h60}};
    exp4 = '{{4'd5, 32'h50}, {4'd2, 32'h40}, {4'd0, 32'h60}, {4'd9, 32'h0}};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_llc_op", 64'(llc_op), 64'd8);
    chk("rst_src",    64'(grant_src), 64'd0);
    chk("rst_l1",     64'(l1_count), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);

    // Single L1 request, one-edge latency, then back to idle.
    step(1, 4'd0, 32'h1000, 0);
    step(0, 4'd0, 32'h0, 0);
    chk("t1_op",   64'(llc_op), 64'd0);
    chk("t1_addr", 64'(llc_addr), 64'h1000);
    chk("t1_src",  64'(grant_src), 64'd1);
    step(0, 4'd0, 32'h0, 0);
    chk("t1_idle_op",  64'(llc_op), 64'd8);
    chk("t1_idle_src", 64'(grant_src), 64'd0);

    // Snoop overtakes an older L1 request.
    step(1, 4'd1, 32'hA0, 1);
    step(1, 4'd4, 32'hB0, 1);
    step(0, 4'd0, 32'h0, 0);
    chk("t2_first_op",  64'(llc_op), 64'd4);
    chk("t2_first_src", 64'(grant_src), 64'd2);
    step(0, 4'd0, 32'h0, 0);
    chk("t2_second_addr", 64'(llc_addr), 64'hA0);
    chk("t2_second_src",  64'(grant_src), 64'd1);
    step(0, 4'd0, 32'h0, 0);

    // Anti-starvation: at most four snoops in a row while L1 waits.
    for (int i = 1; i <= 6; i++) step(1, 4'd3, 32'(i * 16), 1);
    step(1, 4'd0, 32'h99, 1);
    s = glog.size();
    for (int i = 0; i < 7; i++) begin
      step(0, 4'd0, 32'h0, 0);
      chk("t3_dut_addr", 64'(llc_addr), 64'(exp3[i][31:0]));
    end
    for (int i = 0; i < 7; i++) chk_log("t3_model_order", s + i, exp3[i]);
    step(0, 4'd0, 32'h0, 0);

    // Barrier waits for every older request and blocks intake meanwhile.
    step(1, 4'd2, 32'h40, 1);
    step(1, 4'd5, 32'h50, 1);
    step(1, 4'd0, 32'h60, 1);
    s = glog.size();
    step(1, 4'd9, 32'h0, 0);
    chk("t4_ready_closed", 64'(in_ready), 64'd0);
    step(1, 4'd0, 32'h77, 0);
    step(1, 4'd0, 32'h77, 0);
    chk("t4_ready_still_closed", 64'(in_ready), 64'd0);
    step(1, 4'd0, 32'h77, 0);
    chk("t4_bar_op",  64'(llc_op), 64'd9);
    chk("t4_bar_src", 64'(grant_src), 64'd3);
    step(1, 4'd0, 32'h77, 0);
    chk("t4_reopen", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) chk_log("t4_model_order", s + i, exp4[i]);
    step(0, 4'd0, 32'h0, 0);

    // Hold freezes the granted request; enqueue continues underneath.
    step(1, 4'd2, 32'h20, 0);
    step(0, 4'd0, 32'h0, 0);
    chk("t5_c1", 64'(llc_op), 64'd2);
    step(1, 4'd0, 32'h30, 1);
    chk("t5_c2", 64'(llc_op), 64'd2);
    chk("t5_l1_queued", 64'(l1_count), 64'd1);
    step(0, 4'd0, 32'h0, 1);
    chk("t5_c3_addr", 64'(llc_addr), 64'h20);
    step(0, 4'd0, 32'h0, 0);
    chk("t5_next_addr", 64'(llc_addr), 64'h30);
    step(0, 4'd0, 32'h0, 0);

    // Full L1 queue, illegal op, then asynchronous reset mid-stream.
    for (int i = 0; i < DEPTH; i++) step(1, 4'd0, 32'(256 + i), 1);
    chk("t6_full_count", 64'(l1_count), 64'd8);
    chk("t6_full_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    in_valid = 1'b0; in_op = 4'd3;
    #1;
    chk("t6_snoop_open", 64'(in_ready), 64'd1);
    step(1, 4'd7, 32'h0, 1);
    chk("t6_err_pulse", 64'(in_err), 64'd1);
    chk("t6_err_l1",    64'(l1_count), 64'd8);
    chk("t6_err_snp",   64'(snp_count), 64'd0);
    step(0, 4'd0, 32'h0, 0);
    chk("t6_err_clear", 64'(in_err), 64'd0);
    chk("t6_pop_addr",  64'(llc_addr), 64'h100);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_l1",  64'(l1_count), 64'd0);
    chk("t6_rst_snp", 64'(snp_count), 64'd0);
    chk("t6_rst_op",  64'(llc_op), 64'd8);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(0, 4'd0, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
